// File: rtl/stream_downsizer_pkg.sv
// Shared types and defaults for the stream_downsizer width converter.
package stream_downsizer_pkg;

   localparam int unsigned DEF_WIDTH = 32;
   localparam int unsigned DEF_RATIO = 4;

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_t;

   // Width of a slice index; never narrower than one bit.
   function automatic int unsigned idx_width(input int unsigned ratio);
      return (ratio > 1) ? $clog2(ratio) : 1;
   endfunction

endpackage

// File: rtl/stream_downsizer_slice_sel.sv
// Combinational slice mux: picks slice idx of the buffered word.
// Ordering set by DOWNSIZER_MSB_FIRST_EN (defined: MSB slice first; default: LSB first).
module stream_downsizer_slice_sel
   import stream_downsizer_pkg::*;
#(
   parameter  int unsigned WIDTH = DEF_WIDTH,
   parameter  int unsigned RATIO = DEF_RATIO,
   localparam int unsigned OUT_W = WIDTH / RATIO,
   localparam int unsigned LW    = idx_width(RATIO)
) (
   input  logic [WIDTH-1:0] word,
   input  logic [LW-1:0]    idx,
   output logic [OUT_W-1:0] slice
);

   logic [OUT_W-1:0] slices [RATIO];

   for (genvar k = 0; k < RATIO; k++) begin : g_slice
`ifdef DOWNSIZER_MSB_FIRST_EN
      assign slices[k] = word[WIDTH-1-k*OUT_W -: OUT_W];
`else
      assign slices[k] = word[k*OUT_W +: OUT_W];
`endif
   end

   always_comb begin
      slice = slices[idx];
   end

endmodule

// File: rtl/stream_downsizer.sv
// Splits each WIDTH-bit word into up to RATIO OUT_W-bit slices, one per handshake.
// Slice order selected by DOWNSIZER_MSB_FIRST_EN (see stream_downsizer_slice_sel).
module stream_downsizer
   import stream_downsizer_pkg::*;
#(
   parameter  int unsigned WIDTH = DEF_WIDTH,
   parameter  int unsigned RATIO = DEF_RATIO,
   localparam int unsigned OUT_W = WIDTH / RATIO,
   localparam int unsigned LW    = idx_width(RATIO)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             valid_i,
   output logic             ready_o,
   input  logic [WIDTH-1:0] data_i,
   input  logic [LW-1:0]    len_i,
   output logic             valid_o,
   input  logic             ready_i,
   output logic [OUT_W-1:0] data_o,
   output logic             last_o
);

   state_t           state_r;
   logic [WIDTH-1:0] buf_r;
   logic [LW-1:0]    len_r;
   logic [LW-1:0]    idx_r;

   // ready_i feeds ready_o so a new word can load on the last-slice edge.
   always_comb begin
      valid_o = (state_r == SEND);
      last_o  = valid_o & (idx_r == len_r);
      ready_o = (state_r == IDLE) | (valid_o & ready_i & last_o);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= IDLE;
         buf_r   <= '0;
         len_r   <= '0;
         idx_r   <= '0;
      end else begin
         case (state_r)
            IDLE: begin
               if (valid_i) begin
                  state_r <= SEND;
                  buf_r   <= data_i;
                  len_r   <= len_i;
                  idx_r   <= '0;
               end
            end
            SEND: begin
               if (ready_i) begin
                  if (idx_r == len_r) begin
                     if (valid_i) begin
                        buf_r <= data_i;
                        len_r <= len_i;
                        idx_r <= '0;
                     end else begin
                        state_r <= IDLE;
                     end
                  end else begin
                     idx_r <= idx_r + LW'(1);
                  end
               end
            end
            default: state_r <= IDLE;
         endcase
      end
   end

   stream_downsizer_slice_sel #(
      .WIDTH (WIDTH),
      .RATIO (RATIO)
   ) u_slice_sel (
      .word  (buf_r),
      .idx   (idx_r),
      .slice (data_o)
   );

endmodule

// File: tb/tb_stream_downsizer.sv
// Directed self-checking bench for stream_downsizer (WIDTH=32, RATIO=4).
module tb_stream_downsizer;

   localparam int unsigned WIDTH = 32;
   localparam int unsigned RATIO = 4;
   localparam int unsigned OUT_W = 8;
   localparam int unsigned LW    = 2;

   logic             clk;
   logic             rst;
   logic             valid_i;
   logic             ready_o;
   logic [WIDTH-1:0] data_i;
   logic [LW-1:0]    len_i;
   logic             valid_o;
   logic             ready_i;
   logic [OUT_W-1:0] data_o;
   logic             last_o;

   int n_vec;
   int n_err;

   stream_downsizer #(
      .WIDTH (WIDTH),
      .RATIO (RATIO)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .valid_i (valid_i),
      .ready_o (ready_o),
      .data_i  (data_i),
      .len_i   (len_i),
      .valid_o (valid_o),
      .ready_i (ready_i),
      .data_o  (data_o),
      .last_o  (last_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected byte k of a word under the selected slice order.
   function automatic logic [7:0] exp_slice(input logic [31:0] w, input int k);
`ifdef DOWNSIZER_MSB_FIRST_EN
      return w[31-8*k -: 8];
`else
      return w[8*k +: 8];
`endif
   endfunction

   // Present a word at the current negedge and let the next posedge accept it.
   task automatic load_word(input logic [31:0] w, input logic [LW-1:0] l);
      @(negedge clk);
      valid_i = 1'b1;
      data_i  = w;
      len_i   = l;
      ready_i = 1'b1;
      #1;
      n_vec++;
      if (ready_o !== 1'b1) begin
         n_err++;
         $display("FAIL load_ready w=%h got %b exp 1", w, ready_o);
      end
      @(negedge clk);
      valid_i = 1'b0;
      data_i  = '0;
      len_i   = '0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         valid_i = 1'($urandom);
         ready_i = 1'($urandom);
         data_i  = $urandom;
         len_i   = LW'($urandom);
         #1;
         n_vec++;
         if (valid_o !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b exp 0", valid_o); end
         n_vec++;
         if (last_o !== 1'b0) begin n_err++; $display("FAIL reset_last got %b exp 0", last_o); end
         n_vec++;
         if (data_o !== 8'h00) begin n_err++; $display("FAIL reset_data got %h exp 00", data_o); end
         n_vec++;
         if (ready_o !== 1'b1) begin n_err++; $display("FAIL reset_ready got %b exp 1", ready_o); end
      end
      @(negedge clk);
      rst     = 1'b0;
      valid_i = 1'b0;
      ready_i = 1'b0;
      data_i  = '0;
      len_i   = '0;
   endtask

   task automatic test_full_word();
      logic [7:0] exp_b [4];
`ifdef DOWNSIZER_MSB_FIRST_EN
      exp_b = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
`else
      exp_b = '{8'hDD, 8'hCC, 8'hBB, 8'hAA};
`endif
      load_word(32'hAABBCCDD, 2'd3);
      for (int k = 0; k < 4; k++) begin
         #1;
         n_vec++;
         if (valid_o !== 1'b1) begin n_err++; $display("FAIL full_valid k=%0d got %b exp 1", k, valid_o); end
         n_vec++;
         if (data_o !== exp_b[k]) begin n_err++; $display("FAIL full_data k=%0d got %h exp %h", k, data_o, exp_b[k]); end
         n_vec++;
         if (last_o !== (k == 3)) begin n_err++; $display("FAIL full_last k=%0d got %b exp %b", k, last_o, (k == 3)); end
         @(negedge clk);
      end
      #1;
      n_vec++;
      if (valid_o !== 1'b0) begin n_err++; $display("FAIL full_idle got %b exp 0", valid_o); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] w0;
      logic [31:0] w1;
      w0 = 32'h03020100;
      w1 = 32'h07060504;
      @(negedge clk);
      valid_i = 1'b1;
      data_i  = w0;
      len_i   = 2'd3;
      ready_i = 1'b1;
      @(negedge clk);
      data_i = w1;
      for (int k = 0; k < 8; k++) begin
         if (k == 4) begin
            valid_i = 1'b0;
            data_i  = '0;
         end
         #1;
         n_vec++;
         if (valid_o !== 1'b1) begin n_err++; $display("FAIL b2b_valid k=%0d got %b exp 1", k, valid_o); end
         n_vec++;
         if (data_o !== exp_slice((k < 4) ? w0 : w1, k % 4)) begin
            n_err++;
            $display("FAIL b2b_data k=%0d got %h exp %h", k, data_o, exp_slice((k < 4) ? w0 : w1, k % 4));
         end
         n_vec++;
         if (ready_o !== (k % 4 == 3)) begin n_err++; $display("FAIL b2b_ready k=%0d got %b exp %b", k, ready_o, (k % 4 == 3)); end
         @(negedge clk);
      end
      #1;
      n_vec++;
      if (valid_o !== 1'b0) begin n_err++; $display("FAIL b2b_idle got %b exp 0", valid_o); end
   endtask

   task automatic test_backpressure();
      logic [31:0] w;
      w = 32'hAABBCCDD;
      load_word(w, 2'd3);
      for (int k = 0; k < 2; k++) begin
         #1;
         n_vec++;
         if (data_o !== exp_slice(w, k)) begin n_err++; $display("FAIL bp_pre k=%0d got %h exp %h", k, data_o, exp_slice(w, k)); end
         @(negedge clk);
      end
      ready_i = 1'b0;
      for (int c = 0; c < 3; c++) begin
         #1;
         n_vec++;
         if (valid_o !== 1'b1) begin n_err++; $display("FAIL bp_valid c=%0d got %b exp 1", c, valid_o); end
         n_vec++;
         if (data_o !== exp_slice(w, 2)) begin n_err++; $display("FAIL bp_hold c=%0d got %h exp %h", c, data_o, exp_slice(w, 2)); end
         n_vec++;
         if (ready_o !== 1'b0) begin n_err++; $display("FAIL bp_ready c=%0d got %b exp 0", c, ready_o); end
         n_vec++;
         if (last_o !== 1'b0) begin n_err++; $display("FAIL bp_last c=%0d got %b exp 0", c, last_o); end
         @(negedge clk);
      end
      ready_i = 1'b1;
      for (int k = 2; k < 4; k++) begin
         #1;
         n_vec++;
         if (data_o !== exp_slice(w, k)) begin n_err++; $display("FAIL bp_post k=%0d got %h exp %h", k, data_o, exp_slice(w, k)); end
         n_vec++;
         if (ready_o !== (k == 3)) begin n_err++; $display("FAIL bp_post_ready k=%0d got %b exp %b", k, ready_o, (k == 3)); end
         @(negedge clk);
      end
      #1;
      n_vec++;
      if (valid_o !== 1'b0) begin n_err++; $display("FAIL bp_idle got %b exp 0", valid_o); end
   endtask

   task automatic test_partial();
      logic [31:0] w;
      logic [31:0] wn;
      w  = 32'h11223344;
      wn = 32'hCAFEF00D;
      load_word(w, 2'd1);
      #1;
      n_vec++;
      if (data_o !== exp_slice(w, 0) || last_o !== 1'b0) begin
         n_err++;
         $display("FAIL part_s0 got %h/%b exp %h/0", data_o, last_o, exp_slice(w, 0));
      end
      @(negedge clk);
      valid_i = 1'b1;
      data_i  = wn;
      len_i   = 2'd0;
      #1;
      n_vec++;
      if (data_o !== exp_slice(w, 1) || last_o !== 1'b1) begin
         n_err++;
         $display("FAIL part_s1 got %h/%b exp %h/1", data_o, last_o, exp_slice(w, 1));
      end
      n_vec++;
      if (ready_o !== 1'b1) begin n_err++; $display("FAIL part_ready got %b exp 1", ready_o); end
      @(negedge clk);
      valid_i = 1'b0;
      data_i  = '0;
      #1;
      n_vec++;
      if (valid_o !== 1'b1 || data_o !== exp_slice(wn, 0) || last_o !== 1'b1) begin
         n_err++;
         $display("FAIL part_next got %b/%h/%b exp 1/%h/1", valid_o, data_o, last_o, exp_slice(wn, 0));
      end
      @(negedge clk);
      #1;
      n_vec++;
      if (valid_o !== 1'b0) begin n_err++; $display("FAIL part_idle got %b exp 0", valid_o); end
   endtask

   task automatic test_reset_mid_word();
      logic [31:0] w;
      w = 32'h55667788;
      load_word(32'hAABBCCDD, 2'd3);
      #1;
      n_vec++;
      if (data_o !== exp_slice(32'hAABBCCDD, 0)) begin
         n_err++;
         $display("FAIL rmid_s0 got %h exp %h", data_o, exp_slice(32'hAABBCCDD, 0));
      end
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      n_vec++;
      if (valid_o !== 1'b0 || ready_o !== 1'b1 || data_o !== 8'h00) begin
         n_err++;
         $display("FAIL rmid_async got %b/%b/%h exp 0/1/00", valid_o, ready_o, data_o);
      end
      @(negedge clk);
      rst = 1'b0;
      load_word(w, 2'd3);
      for (int k = 0; k < 4; k++) begin
         #1;
         n_vec++;
         if (valid_o !== 1'b1 || data_o !== exp_slice(w, k) || last_o !== (k == 3)) begin
            n_err++;
            $display("FAIL rmid_post k=%0d got %b/%h/%b exp 1/%h/%b", k, valid_o, data_o, last_o, exp_slice(w, k), (k == 3));
         end
         @(negedge clk);
      end
      #1;
      n_vec++;
      if (valid_o !== 1'b0) begin n_err++; $display("FAIL rmid_idle got %b exp 0", valid_o); end
   endtask

   initial begin
      n_vec   = 0;
      n_err   = 0;
      rst     = 1'b1;
      valid_i = 1'b0;
      ready_i = 1'b0;
      data_i  = '0;
      len_i   = '0;
      test_reset();
      test_full_word();
      test_back_to_back();
      test_backpressure();
      test_partial();
      test_reset_mid_word();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
